twos_complement_serial: RTL and testbench



---
 rtl/twos_pkg.sv | 35 +++
 rtl/twos_complement_serial_slice.sv | 18 +
 rtl/twos_complement_serial.sv | 129 ++++++++++++
 tb/tb_twos_complement_serial.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/twos_pkg.sv
// Shared definitions for the digit-serial two's-complement unit.
// Mode codes, FSM state codes and the per-mode invert/carry rule.
package twos_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic inv;
        logic cin;
    } ctl_t;

    // ABS negates only when the operand is negative.
    function automatic ctl_t mode_ctl(
        input logic [1:0] mode,
        input logic       msb
    );
        ctl_t c;
        c = '0;
        case (mode)
            MODE_PASS: c = '{inv: 1'b0, cin: 1'b0};
            MODE_ONES: c = '{inv: 1'b1, cin: 1'b0};
            MODE_NEG:  c = '{inv: 1'b1, cin: 1'b1};
            default:   c = '{inv: msb,  cin: msb};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/twos_complement_serial_slice.sv
// One DIGIT-wide chunk of the serial datapath: optional invert plus carry.
// Ports: chunk/inv/cin in, r/cout out; purely combinational.
module twos_digit_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] chunk,
    input  logic             inv,
    input  logic             cin,
    output logic [DIGIT-1:0] r,
    output logic             cout
);

    logic [DIGIT-1:0] opnd;

    assign opnd      = inv ? ~chunk : chunk;
    assign {cout, r} = {1'b0, opnd} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/twos_complement_serial.sv
// Digit-serial pass / ones / negate / abs unit, LSB chunk first.
// Ports: clk, rst_n, en, mode, A in; Output, ready, busy, ovf, zero out.
module twos_complement_serial
    import twos_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Output,
    output logic             ready,
    output logic             busy,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0]       r;
    logic                   cout;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       sr_next;
    ctl_t                   ctl;

    twos_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .chunk (sr_q[DIGIT-1:0]),
        .inv   (inv_q),
        .cin   (carry_q),
        .r     (r),
        .cout  (cout)
    );

    // New digit enters at the top; after N shifts the register
    // holds the complete result in its natural bit order.
    assign cat     = {r, sr_q};
    assign sr_next = cat[WIDTH+DIGIT-1:DIGIT];
    assign ctl     = mode_ctl(mode, A[WIDTH-1]);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        inv_d      = inv_q;
        ovf_pend_d = ovf_pend_q;
        out_d      = out_q;
        ready_d    = 1'b0;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    sr_d       = A;
                    cnt_d      = '0;
                    inv_d      = ctl.inv;
                    carry_d    = ctl.cin;
                    ovf_pend_d = (mode == MODE_NEG || mode == MODE_ABS)
                                 && (A == MOST_NEG);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                sr_d    = sr_next;
                carry_d = cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    out_d   = sr_next;
                    ovf_d   = ovf_pend_q;
                    zero_d  = (sr_next == '0);
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            inv_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            inv_q      <= inv_d;
            ovf_pend_q <= ovf_pend_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign Output = out_q;
    assign ready  = ready_q;
    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_twos_complement_serial.sv
// Randomised and directed bench for twos_complement_serial.
// Three configurations: 8/2, 16/4 and 8/1 (WIDTH/DIGIT).
module tb_twos_complement_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en_v;
    logic [1:0]  mode;
    logic [15:0] A;

    logic [7:0]  out0, out2;
    logic [15:0] out1;
    logic [2:0]  ready_v, busy_v, ovf_v, zero_v;
    logic [15:0] out_v [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    twos_complement_serial #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .mode(mode), .A(A[7:0]),
        .Output(out0), .ready(ready_v[0]), .busy(busy_v[0]),
        .ovf(ovf_v[0]), .zero(zero_v[0])
    );
    twos_complement_serial #(.WIDTH(16), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .mode(mode), .A(A),
        .Output(out1), .ready(ready_v[1]), .busy(busy_v[1]),
        .ovf(ovf_v[1]), .zero(zero_v[1])
    );
    twos_complement_serial #(.WIDTH(8), .DIGIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .mode(mode), .A(A[7:0]),
        .Output(out2), .ready(ready_v[2]), .busy(busy_v[2]),
        .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    assign out_v[0] = {8'h00, out0};
    assign out_v[1] = out1;
    assign out_v[2] = {8'h00, out2};

    function automatic int wid(input int sel);
        return (sel == 1) ? 16 : 8;
    endfunction

    function automatic int nchunks(input int sel);
        case (sel)
            0: return 4;
            1: return 4;
            default: return 8;
        endcase
    endfunction

    // Reference: plain arithmetic on the operand value.
    function automatic logic [15:0] model_res(
        input int w, input logic [15:0] a, input logic [1:0] m
    );
        logic [15:0] mask, av, neg;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        av   = a & mask;
        neg  = (16'd0 - av) & mask;
        case (m)
            2'd0: return av;
            2'd1: return ~av & mask;
            2'd2: return neg;
            default: return (av >= (16'd1 << (w - 1))) ? neg : av;
        endcase
    endfunction

    function automatic logic model_ovf(
        input int w, input logic [15:0] a, input logic [1:0] m
    );
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        return (m == 2'd2 || m == 2'd3) && ((a & mask) == (16'd1 << (w - 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input int sel, input logic [15:0] a,
                         input logic [1:0] m);
        @(negedge clk);
        A = a;
        mode = m;
        en_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        en_v[sel] = 1'b0;
    endtask

    task automatic wait_ready(input int sel, output int lat, output bit bz_ok);
        lat = 0;
        bz_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy_v[sel]) bz_ok = 1'b0;
        end while (!ready_v[sel] && lat < 40);
    endtask

    task automatic run_chk(input int sel, input logic [15:0] a,
                           input logic [1:0] m, input string tag);
        int lat;
        bit bz;
        logic [15:0] exp;
        exp = model_res(wid(sel), a, m);
        start(sel, a, m);
        wait_ready(sel, lat, bz);
        check({tag, ".lat"}, lat, nchunks(sel));
        check({tag, ".busy"}, bz, 1);
        check({tag, ".out"}, out_v[sel], exp);
        check({tag, ".ovf"}, ovf_v[sel], model_ovf(wid(sel), a, m));
        check({tag, ".zero"}, zero_v[sel], exp == 16'd0);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, ready_v[sel], 1'b0);
        check({tag, ".idle"}, busy_v[sel], 1'b0);
    endtask

    initial begin
        int lat;
        bit bz;
        int rdy_cnt;
        logic [15:0] a;
        logic [1:0] m;

        rst_n = 1'b0;
        en_v = '0;
        mode = 2'd0;
        A = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out", out_v[0], 0);
        check("rst.ready", ready_v, 0);
        check("rst.busy", busy_v, 0);
        check("rst.ovf", ovf_v, 0);
        check("rst.zero", zero_v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_chk(0, 16'h000C, 2'd2, "neg12");
        run_chk(0, 16'h0080, 2'd2, "neg80");
        run_chk(0, 16'h0080, 2'd3, "abs80");
        run_chk(0, 16'h0000, 2'd2, "neg0");
        run_chk(0, 16'h00F4, 2'd3, "absF4");
        run_chk(0, 16'h0035, 2'd3, "abs35");
        run_chk(0, 16'h0035, 2'd1, "ones35");
        run_chk(0, 16'h0035, 2'd0, "pass35");
        run_chk(1, 16'h8000, 2'd3, "abs8000");
        run_chk(2, 16'h0001, 2'd2, "neg1_d1");

        // en held high: mid-run operand change ignored, then restart.
        @(negedge clk);
        A = 16'h000C;
        mode = 2'd2;
        en_v[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        A = 16'h0001;
        wait_ready(0, lat, bz);
        check("hold.first", out_v[0], 16'h00F4);
        wait_ready(0, lat, bz);
        en_v[0] = 1'b0;
        check("hold.second", out_v[0], 16'h00FF);
        @(posedge clk);
        #1;
        check("hold.idle", busy_v[0], 1'b0);

        // Reset on the second RUN cycle aborts the operation.
        start(0, 16'h000C, 2'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort.out", out_v[0], 0);
        check("abort.ready", ready_v[0], 0);
        check("abort.busy", busy_v[0], 0);
        check("abort.ovf", ovf_v[0], 0);
        check("abort.zero", zero_v[0], 0);
        rst_n = 1'b1;
        rdy_cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ready_v[0]) rdy_cnt++;
        end
        check("abort.noready", rdy_cnt, 0);
        run_chk(0, 16'h0005, 2'd2, "neg5");

        for (int s = 0; s < 3; s++) begin
            int nops;
            nops = (s == 0) ? 300 : 1000;
            for (int i = 0; i < nops; i++) begin
                case ($urandom_range(0, 7))
                    0: a = 16'h0000;
                    1: a = (s == 1) ? 16'h8000 : 16'h0080;
                    2: a = 16'hFFFF;
                    default: a = 16'($urandom);
                endcase
                if (s != 1) a[15:8] = 8'h00;
                m = 2'($urandom_range(0, 3));
                run_chk(s, a, m, $sformatf("rnd%0d_%0d", s, i));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
